// File: rtl/rgb_phase_scheduler.sv
// Cycle-timed phase sequencer for a two-head RGB traffic light on a 6-bit LED bank.
// Crossing requests can cut green short; a second button toggles a blinking-yellow service mode.
module rgb_phase_scheduler #(
    parameter int unsigned INIT_CYC      = 130_000_000,
    parameter int unsigned GREEN_CYC     = 650_000_000,
    parameter int unsigned MIN_GREEN_CYC = 260_000_000,
    parameter int unsigned YELLOW_CYC    = 260_000_000,
    parameter int unsigned ALLRED_CYC    = 130_000_000,
    parameter int unsigned FLASH_HALF    = 65_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] push,
    output logic [2:0] state,
    output logic [5:0] led_output,
    output logic       req_pending
);

    localparam logic [2:0] Red    = 3'b100;
    localparam logic [2:0] Green  = 3'b010;
    localparam logic [2:0] Yellow = 3'b110;
    localparam logic [2:0] Off    = 3'b000;

    typedef enum logic [2:0] {
        StInit    = 3'd0,
        StAGo     = 3'd1,
        StAWarn   = 3'd2,
        StAllRed1 = 3'd3,
        StBGo     = 3'd4,
        StBWarn   = 3'd5,
        StAllRed2 = 3'd6,
        StFlash   = 3'd7
    } phase_e;

    phase_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ft_q, ft_d;
    logic        req_q, req_d;
    logic [1:0]  push_q;
    logic [5:0]  led_q, led_d;
    logic [1:0]  push_edge;
    logic        entering;

    assign push_edge = push & ~push_q;

    // push_q follows the buttons even in reset so a held button yields no edge on release.
    always_ff @(posedge clk) begin
        push_q <= push;
        if (!resetn) begin
            state_q <= StInit;
            cnt_q   <= '0;
            ft_q    <= 1'b0;
            req_q   <= 1'b0;
            led_q   <= 6'b111_111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ft_q    <= ft_d;
            req_q   <= req_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:    if (cnt_q == INIT_CYC - 1) state_d = StAGo;
            StAGo:     if (cnt_q == GREEN_CYC - 1 || (req_q && cnt_q >= MIN_GREEN_CYC - 1))
                           state_d = StAWarn;
            StAWarn:   if (cnt_q == YELLOW_CYC - 1) state_d = StAllRed1;
            StAllRed1: if (cnt_q == ALLRED_CYC - 1) state_d = StBGo;
            StBGo:     if (cnt_q == GREEN_CYC - 1 || (req_q && cnt_q >= MIN_GREEN_CYC - 1))
                           state_d = StBWarn;
            StBWarn:   if (cnt_q == YELLOW_CYC - 1) state_d = StAllRed2;
            StAllRed2: if (cnt_q == ALLRED_CYC - 1) state_d = StAGo;
            StFlash:   state_d = StFlash;
        endcase
        if (push_edge[1]) begin
            state_d = (state_q == StFlash) ? StAllRed2 : StFlash;
        end

        entering = (state_d != state_q);
        if (entering) begin
            cnt_d = '0;
            ft_d  = 1'b0;
        end else if (state_q == StFlash && cnt_q == FLASH_HALF - 1) begin
            cnt_d = '0;
            ft_d  = ~ft_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
            ft_d  = ft_q;
        end

        // Clearing on WARN/FLASH entry takes priority over a same-cycle new request.
        req_d = req_q;
        if (push_edge[0] && state_q != StFlash) req_d = 1'b1;
        if (entering && (state_d == StAWarn || state_d == StBWarn || state_d == StFlash)) begin
            req_d = 1'b0;
        end
    end

    always_comb begin
        led_d = 6'b111_111;
        unique case (state_d)
            StInit:    led_d = 6'b111_111;
            StAGo:     led_d = {Green, Red};
            StAWarn:   led_d = {Yellow, Red};
            StAllRed1: led_d = {Red, Red};
            StBGo:     led_d = {Red, Green};
            StBWarn:   led_d = {Red, Yellow};
            StAllRed2: led_d = {Red, Red};
            StFlash:   led_d = ft_d ? {Off, Off} : {Yellow, Yellow};
        endcase
    end

    assign state       = state_q;
    assign led_output  = led_q;
    assign req_pending = req_q;

endmodule
